bypass_fifo2: RTL and testbench

Two-entry, single-clock FIFO with a combinational bypass path: when empty, a word presented on the enqueue side is visible on the dequeue side in the same cycle and can be consumed without being stored. It sits directly upstream of the bypass crossing wire in the BSV primitive set. Its dequeue side drives the wire's value input, so a producer rule and a consumer rule in the same clock domain can hand off data with zero added latency while still absorbing up to two cycles of backpressure.

---
 rtl/bsv_fifo_pkg.sv | 17 +
 rtl/bypass_fifo2.sv | 82 ++++++++
 tb/tb_bypass_fifo2.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bsv_fifo_pkg.sv
// Occupancy encodings for the BSV FIFO family. The sized and pipelined FIFOs reuse them.
package bsv_fifo_pkg;

    localparam int COUNT_W = 2;

    typedef enum logic [COUNT_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } count_t;

    // The unreachable encoding 3 has bit 1 set, so it reads as TWO.
    function automatic logic count_is_full(input count_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/bypass_fifo2.sv
// Two-entry FIFO with a same-cycle bypass from D_IN to D_OUT when empty.
//
// state | meaning
// EMPTY | no stored word; D_OUT shows D_IN, ENQ&DEQ passes straight through
// ONE   | data0 holds the head
// TWO   | data0 head, data1 tail; no space
module bypass_fifo2
    import bsv_fifo_pkg::*;
#(
    parameter int width   = 1,
    parameter bit guarded = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    output logic             FULL_N,
    output logic [width-1:0] D_OUT,
    input  logic             DEQ,
    output logic             EMPTY_N,
    input  logic             CLR
);

    count_t           count;
    logic [width-1:0] data0;
    logic [width-1:0] data1;

    // FULL_N looks only at stored occupancy, never at DEQ, so ENQ/DEQ form no loop.
    assign FULL_N  = !count_is_full(count) && !RST;
    assign EMPTY_N = ((count != EMPTY) || ENQ) && !RST;
    assign D_OUT   = (count != EMPTY) ? data0 : D_IN;

    // Occupancy and storage update; CLR wins over strobes, illegal strobes are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= EMPTY;
            data0 <= '0;
            data1 <= '0;
        end else if (CLR) begin
            count <= EMPTY;
        end else begin
            case (count)
                EMPTY: begin
                    if (ENQ && !DEQ) begin
                        count <= ONE;
                        data0 <= D_IN;
                    end
                end
                ONE: begin
                    if (ENQ && DEQ) begin
                        data0 <= D_IN;
                    end else if (ENQ) begin
                        count <= TWO;
                        data1 <= D_IN;
                    end else if (DEQ) begin
                        count <= EMPTY;
                    end
                end
                default: begin
                    // TWO (and the stray encoding 3): an ENQ here is dropped.
                    if (DEQ) begin
                        count <= ONE;
                        data0 <= data1;
                    end
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Simulation-only report of strobes issued against a full or empty FIFO.
    always @(posedge CLK) begin
        if (guarded && !RST && !CLR) begin
            if (ENQ && count_is_full(count))
                $error("%m: ENQ while full, word dropped");
            if (DEQ && !ENQ && (count == EMPTY))
                $error("%m: DEQ while empty, ignored");
        end
    end
`endif

endmodule

// File: tb/tb_bypass_fifo2.sv
// Scoreboard bench for bypass_fifo2: a queue-based model predicts per-cycle outputs,
// a negedge monitor compares them against the DUT.
module tb_bypass_fifo2;

    typedef struct packed {
        logic [7:0] dout;
        logic       full_n;
        logic       empty_n;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] D_IN = 8'h00;
    logic       ENQ = 1'b0;
    logic       DEQ = 1'b0;
    logic       CLR = 1'b0;
    logic       FULL_N;
    logic       EMPTY_N;
    logic [7:0] D_OUT;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    int         checks = 0;
    int         errors = 0;

    bypass_fifo2 #(.width(8), .guarded(1'b0)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .D_IN    (D_IN),
        .ENQ     (ENQ),
        .FULL_N  (FULL_N),
        .D_OUT   (D_OUT),
        .DEQ     (DEQ),
        .EMPTY_N (EMPTY_N),
        .CLR     (CLR)
    );

    always #5 CLK = ~CLK;

    // Apply one cycle of stimulus, predict the outputs from the model queue,
    // then advance the model across the clock edge.
    task automatic step(input logic rst, input logic clr, input logic enq,
                        input logic deq, input logic [7:0] din);
        exp_t e;
        int   n;
        RST  = rst;
        CLR  = clr;
        ENQ  = enq;
        DEQ  = deq;
        D_IN = din;
        n = mq.size();
        e.full_n  = !rst && (n < 2);
        e.empty_n = !rst && ((n > 0) || enq);
        e.dout    = (!rst && n > 0) ? mq[0] : din;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        if (rst || clr) begin
            mq.delete();
        end else begin
            if (deq && n > 0) void'(mq.pop_front());
            if (enq && n < 2 && !(deq && n == 0)) mq.push_back(din);
        end
    endtask

    // Monitor: one expected record per cycle, compared away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (FULL_N !== e.full_n) begin
                    errors++;
                    $display("FAIL full_n t=%0t got %b want %b", $time, FULL_N, e.full_n);
                end
                checks++;
                if (EMPTY_N !== e.empty_n) begin
                    errors++;
                    $display("FAIL empty_n t=%0t got %b want %b", $time, EMPTY_N, e.empty_n);
                end
                checks++;
                if (D_OUT !== e.dout) begin
                    errors++;
                    $display("FAIL d_out t=%0t got %h want %h", $time, D_OUT, e.dout);
                end
            end
        end
    end

    initial begin
        logic r, c, en, dq;
        @(posedge CLK);
        #1;
        // Reset state.
        step(1, 0, 0, 0, 8'h5C);
        step(1, 0, 1, 1, 8'h3E);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h77);
        step(0, 0, 0, 1, 8'h00);
        // Bypass from EMPTY.
        repeat (10) step(0, 0, 1, 1, 8'hA5);
        step(0, 0, 0, 0, 8'h00);
        // Fill and drain.
        step(0, 0, 1, 0, 8'h11);
        step(0, 0, 1, 0, 8'h22);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        // Steady ONE.
        step(0, 0, 1, 0, 8'h01);
        for (int i = 2; i <= 9; i++) step(0, 0, 1, 1, 8'(i));
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        // CLR beats ENQ/DEQ.
        step(0, 0, 1, 0, 8'h44);
        step(0, 0, 1, 0, 8'h55);
        step(0, 1, 1, 1, 8'h66);
        step(0, 0, 0, 0, 8'h00);
        // Illegal ENQ when full, illegal DEQ when empty.
        step(0, 0, 1, 0, 8'h11);
        step(0, 0, 1, 0, 8'h22);
        step(0, 0, 1, 0, 8'h33);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        // Reset mid-stream while full.
        step(0, 0, 1, 0, 8'h81);
        step(0, 0, 1, 0, 8'h82);
        step(1, 0, 0, 0, 8'h83);
        step(0, 0, 0, 0, 8'h84);
        step(0, 0, 0, 1, 8'h85);
        // Randomized traffic, illegal strobes included.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 29) == 0);
            en = ($urandom_range(0, 9) < 6);
            dq = ($urandom_range(0, 9) < 5);
            step(r, c, en, dq, 8'($urandom));
        end
        step(0, 0, 0, 0, 8'h00);
        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
